// File: rtl/sram_arb_2to1.sv
`default_nettype none
// ============================================================================
// sram_arb_2to1 : two request/response masters sharing one single-port SRAM
//                 with one-cycle registered read data.
// Option        : define SRAM_ARB_RR_EN for round-robin arbitration; without
//                 it port 0 has fixed priority.
// Revision      : 1.0 - initial release
// ============================================================================
module sram_arb_2to1 #(
    parameter int AW = 14,
    parameter int DW = 128
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_write,
    input  logic [AW-1:0]     m0_req_addr,
    input  logic [DW-1:0]     m0_req_wdata,
    input  logic [DW/8-1:0]   m0_req_wstrb,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DW-1:0]     m0_rsp_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_write,
    input  logic [AW-1:0]     m1_req_addr,
    input  logic [DW-1:0]     m1_req_wdata,
    input  logic [DW/8-1:0]   m1_req_wstrb,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DW-1:0]     m1_rsp_rdata,

    output logic [AW-1:0]     sram_a,
    output logic              sram_cen,
    output logic [DW-1:0]     sram_d,
    output logic [DW/8-1:0]   sram_wen,
    input  logic [DW-1:0]     sram_q
);

    localparam int BW = DW / 8;

    logic [1:0]    elig;
    logic [1:0]    grant;
    logic          sel;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [BW-1:0] sel_wstrb;
    logic          acc_read;
    logic          sram_access;

    logic          infl_valid_q, infl_valid_d;
    logic          infl_id_q, infl_id_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
`ifdef SRAM_ARB_RR_EN
    logic          prio_q, prio_d;
`endif

    // A read is only admitted when its response slot is guaranteed free.
    always_comb begin
        elig[0] = m0_req_valid &
                  (m0_req_write | ~((infl_valid_q & ~infl_id_q) | rsp_valid_q[0]));
        elig[1] = m1_req_valid &
                  (m1_req_write | ~((infl_valid_q &  infl_id_q) | rsp_valid_q[1]));
    end

    always_comb begin
        grant = 2'b00;
        if (!RST) begin
            if (elig == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
                grant = prio_q ? 2'b10 : 2'b01;
`else
                grant = 2'b01;
`endif
            end else begin
                grant = elig;
            end
        end
    end

    always_comb begin
        sel       = grant[1];
        sel_write = sel ? m1_req_write : m0_req_write;
        sel_addr  = sel ? m1_req_addr  : m0_req_addr;
        sel_wdata = sel ? m1_req_wdata : m0_req_wdata;
        sel_wstrb = sel ? m1_req_wstrb : m0_req_wstrb;
        // An all-zero-strobe write is accepted but must not touch the SRAM.
        sram_access = (|grant) & (~sel_write | (|sel_wstrb));
        acc_read    = (|grant) & ~sel_write;
    end

    assign m0_req_ready = grant[0];
    assign m1_req_ready = grant[1];
    assign sram_a       = sel_addr;
    assign sram_d       = sel_wdata;
    assign sram_cen     = ~sram_access;
    assign sram_wen     = ((|grant) & sel_write) ? ~sel_wstrb : {BW{1'b1}};

    assign m0_rsp_valid = rsp_valid_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m0_rsp_rdata = rsp0_rdata_q;
    assign m1_rsp_rdata = rsp1_rdata_q;

    always_comb begin
        infl_valid_d = acc_read;
        infl_id_d    = sel;
        rsp_valid_d  = rsp_valid_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        if (rsp_valid_q[0] & m0_rsp_ready) rsp_valid_d[0] = 1'b0;
        if (rsp_valid_q[1] & m1_rsp_ready) rsp_valid_d[1] = 1'b0;
        if (infl_valid_q & ~infl_id_q) begin
            rsp_valid_d[0] = 1'b1;
            rsp0_rdata_d   = sram_q;
        end
        if (infl_valid_q & infl_id_q) begin
            rsp_valid_d[1] = 1'b1;
            rsp1_rdata_d   = sram_q;
        end
`ifdef SRAM_ARB_RR_EN
        prio_d = prio_q;
        if (|grant) prio_d = grant[0];
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            infl_valid_q <= 1'b0;
            infl_id_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
            prio_q       <= 1'b0;
`endif
        end else begin
            infl_valid_q <= infl_valid_d;
            infl_id_q    <= infl_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
`ifdef SRAM_ARB_RR_EN
            prio_q       <= prio_d;
`endif
        end
    end

endmodule
`default_nettype wire
